// File: rtl/gmii_rx_ts.sv
// gmii_rx_ts: byte-wide receive front end for a host port.
// Strips the preamble and SFD, timestamps the frame at the SFD byte, and
// forwards frame bytes on a sop/eop stream. A one-byte hold stage delays
// each byte so the last byte can be tagged eop when RXDV drops. The stream
// ends with a per-frame descriptor (length, timestamp, error).
module gmii_rx_ts #(
    parameter int MAX_LEN = 1522,   // largest accepted frame incl. FCS, <= 2047
    parameter int MIN_LEN = 64      // smallest accepted frame incl. FCS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] local_clock,
    input  logic [7:0]  RXD,
    input  logic        RXDV,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sop,
    output logic        rx_eop,
    output logic        rx_err,
    output logic        desc_valid,
    output logic [10:0] desc_len,
    output logic [31:0] desc_ts,
    output logic        desc_err,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    localparam logic [10:0] MAX_L    = 11'(MAX_LEN);
    localparam logic [10:0] MIN_L    = 11'(MIN_LEN);
    localparam logic [7:0]  PRE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE = 8'hD5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t      state_r;
    logic        rxdv_d_r;
    logic [2:0]  pre_cnt_r;
    logic [10:0] len_r;
    logic [31:0] ts_r;
    logic [7:0]  hold_r;
    logic        hold_full_r;
    logic        sop_pend_r;
    logic        short_s;

    // A frame is in error when it is shorter than MIN_LEN or carried no data at all.
    always_comb begin
        short_s = 1'b0;
        if ((len_r < MIN_L) || (len_r == 11'd0)) begin
            short_s = 1'b1;
        end else begin
            short_s = 1'b0;
        end
    end

    // Delayed RXDV for start-of-burst detection; resets high so a burst already
    // in flight at reset release is ignored until RXDV drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxdv_d_r <= 1'b1;
        end else begin
            rxdv_d_r <= RXDV;
        end
    end

    // Receive FSM with hold stage, stream outputs, descriptor and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            pre_cnt_r   <= 3'd0;
            len_r       <= 11'd0;
            ts_r        <= 32'd0;
            hold_r      <= 8'd0;
            hold_full_r <= 1'b0;
            sop_pend_r  <= 1'b0;
            rx_data     <= 8'd0;
            rx_valid    <= 1'b0;
            rx_sop      <= 1'b0;
            rx_eop      <= 1'b0;
            rx_err      <= 1'b0;
            desc_valid  <= 1'b0;
            desc_len    <= 11'd0;
            desc_ts     <= 32'd0;
            desc_err    <= 1'b0;
            frame_cnt   <= 16'd0;
            err_cnt     <= 16'd0;
        end else begin
            // Per-beat strobes are single-cycle unless re-asserted below.
            rx_valid   <= 1'b0;
            rx_sop     <= 1'b0;
            rx_eop     <= 1'b0;
            rx_err     <= 1'b0;
            desc_valid <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (RXDV && !rxdv_d_r) begin
                        if (RXD == PRE_BYTE) begin
                            state_r   <= ST_PRE;
                            pre_cnt_r <= 3'd1;
                        end else begin
                            state_r <= ST_DROP;
                            err_cnt <= err_cnt + 16'd1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_PRE: begin
                    if (!RXDV) begin
                        state_r <= ST_IDLE;
                        err_cnt <= err_cnt + 16'd1;
                    end else if (RXD == PRE_BYTE) begin
                        if (pre_cnt_r != 3'd7) begin
                            pre_cnt_r <= pre_cnt_r + 3'd1;
                        end else begin
                            pre_cnt_r <= pre_cnt_r;
                        end
                    end else if (RXD == SFD_BYTE) begin
                        state_r     <= ST_DATA;
                        ts_r        <= local_clock;
                        len_r       <= 11'd0;
                        hold_full_r <= 1'b0;
                        sop_pend_r  <= 1'b1;
                    end else begin
                        state_r <= ST_DROP;
                        err_cnt <= err_cnt + 16'd1;
                    end
                end

                ST_DATA: begin
                    if (!RXDV) begin
                        // End of frame: flush the held byte as eop and emit the descriptor.
                        if (hold_full_r) begin
                            rx_data  <= hold_r;
                            rx_valid <= 1'b1;
                            rx_sop   <= sop_pend_r;
                            rx_eop   <= 1'b1;
                            rx_err   <= short_s;
                        end else begin
                            rx_valid <= 1'b0;
                        end
                        desc_valid  <= 1'b1;
                        desc_len    <= len_r;
                        desc_ts     <= ts_r;
                        desc_err    <= short_s;
                        if (short_s) begin
                            err_cnt <= err_cnt + 16'd1;
                        end else begin
                            frame_cnt <= frame_cnt + 16'd1;
                        end
                        hold_full_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else if (len_r == MAX_L) begin
                        // Oversize: terminate the stream at MAX_LEN and drop the rest.
                        rx_data     <= hold_r;
                        rx_valid    <= hold_full_r;
                        rx_sop      <= sop_pend_r;
                        rx_eop      <= 1'b1;
                        rx_err      <= 1'b1;
                        desc_valid  <= 1'b1;
                        desc_len    <= MAX_L;
                        desc_ts     <= ts_r;
                        desc_err    <= 1'b1;
                        err_cnt     <= err_cnt + 16'd1;
                        hold_full_r <= 1'b0;
                        state_r     <= ST_DROP;
                    end else begin
                        hold_r      <= RXD;
                        hold_full_r <= 1'b1;
                        len_r       <= len_r + 11'd1;
                        if (hold_full_r) begin
                            rx_data    <= hold_r;
                            rx_valid   <= 1'b1;
                            rx_sop     <= sop_pend_r;
                            sop_pend_r <= 1'b0;
                        end else begin
                            sop_pend_r <= sop_pend_r;
                        end
                    end
                end

                ST_DROP: begin
                    if (!RXDV) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DROP;
                    end
                end

                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_rx_ts.sv
// tb_gmii_rx_ts: table of directed frames, hand-written back-to-back and
// mid-frame reset sequences, and random frames checked against a
// frame-level reference model.
module tb_gmii_rx_ts;

    localparam int MAX_LEN = 1522;
    localparam int MIN_LEN = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] local_clock = 32'd0;
    logic [7:0]  RXD = 8'd0;
    logic        RXDV = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sop, rx_eop, rx_err;
    logic        desc_valid;
    logic [10:0] desc_len;
    logic [31:0] desc_ts;
    logic        desc_err;
    logic [15:0] frame_cnt, err_cnt;

    gmii_rx_ts #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN)) dut (
        .clk(clk), .rst(rst), .local_clock(local_clock), .RXD(RXD), .RXDV(RXDV),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_sop(rx_sop), .rx_eop(rx_eop),
        .rx_err(rx_err), .desc_valid(desc_valid), .desc_len(desc_len),
        .desc_ts(desc_ts), .desc_err(desc_err), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    logic [31:0] cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    typedef struct packed {
        logic [7:0]  data;
        logic        sop;
        logic        eop;
        logic        err;
        logic [31:0] cyc;
    } beat_t;

    typedef struct packed {
        logic [10:0] len;
        logic [31:0] ts;
        logic        err;
        logic [31:0] cyc;
    } desc_t;

    beat_t got_b[$], exp_b[$];
    desc_t got_d[$], exp_d[$];
    int    stray = 0;

    // Monitor: collect every beat and descriptor, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) got_b.push_back('{data: rx_data, sop: rx_sop, eop: rx_eop, err: rx_err, cyc: cyc});
            else if (rx_sop || rx_eop || rx_err) stray++;
            if (desc_valid) got_d.push_back('{len: desc_len, ts: desc_ts, err: desc_err, cyc: cyc});
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [7:0]  frm[$];
    logic [31:0] edg[$];
    logic [31:0] lcl[$];

    task automatic tick(input logic [7:0] d, input logic dv);
        RXD = d;
        RXDV = dv;
        @(posedge clk);
        #1;
        local_clock = local_clock + 32'd1;
    endtask

    task automatic send(input int gap);
        edg.delete();
        lcl.delete();
        foreach (frm[i]) begin
            lcl.push_back(local_clock);
            RXD = frm[i];
            RXDV = 1'b1;
            @(posedge clk);
            #1;
            edg.push_back(cyc);
            local_clock = local_clock + 32'd1;
        end
        for (int i = 0; i < gap; i++) tick(8'h00, 1'b0);
    endtask

    // ---------------- frame-level reference model ----------------
    logic [15:0] m_frm = 16'd0;
    logic [15:0] m_err = 16'd0;

    function automatic void model();
        int   p = 0;
        int   sfd, l, n;
        logic bad_len;
        while (p < frm.size() && frm[p] == 8'h55) p++;
        if (p == 0 || p == frm.size() || frm[p] != 8'hD5) begin
            m_err = m_err + 16'd1;
            return;
        end
        sfd = p;
        l = frm.size() - sfd - 1;
        n = (l > MAX_LEN) ? MAX_LEN : l;
        bad_len = (l < MIN_LEN) || (l > MAX_LEN);
        for (int i = 0; i < n; i++)
            exp_b.push_back('{data: frm[sfd + 1 + i], sop: (i == 0), eop: (i == n - 1),
                              err: ((i == n - 1) && bad_len), cyc: edg[sfd + 1 + i] + 32'd1});
        exp_d.push_back('{len: 11'(n), ts: lcl[sfd], err: bad_len, cyc: edg[sfd + n] + 32'd1});
        if (bad_len) m_err = m_err + 16'd1;
        else m_frm = m_frm + 16'd1;
    endfunction

    desc_t last_d;
    bit    have_d = 1'b0;

    task automatic compare_all(input string tag);
        int nb = 0, first = -1, ndd = 0;
        for (int i = 0; i < 3; i++) tick(8'h00, 1'b0);
        chk({tag, " beat count"}, 64'(got_b.size()), 64'(exp_b.size()));
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
            if (got_b[i] !== exp_b[i]) begin
                if (first < 0) first = i;
                nb++;
            end
        chk($sformatf("%s beats differing (first idx %0d)", tag, first), 64'(nb), 64'd0);
        chk({tag, " desc count"}, 64'(got_d.size()), 64'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++)
            if (got_d[i] !== exp_d[i]) ndd++;
        chk({tag, " descs differing"}, 64'(ndd), 64'd0);
        chk({tag, " frame_cnt"}, 64'(frame_cnt), 64'(m_frm));
        chk({tag, " err_cnt"}, 64'(err_cnt), 64'(m_err));
        chk({tag, " stray strobes"}, 64'(stray), 64'd0);
        if (exp_d.size() > 0) begin
            last_d = exp_d[exp_d.size() - 1];
            have_d = 1'b1;
        end
        if (have_d) begin
            chk({tag, " desc_len held"}, 64'(desc_len), 64'(last_d.len));
            chk({tag, " desc_ts held"}, 64'(desc_ts), 64'(last_d.ts));
            chk({tag, " desc_err held"}, 64'(desc_err), 64'(last_d.err));
        end
        got_b.delete(); exp_b.delete(); got_d.delete(); exp_d.delete();
    endtask

    task automatic add_pre_sfd();
        for (int i = 0; i < 7; i++) frm.push_back(8'h55);
        frm.push_back(8'hD5);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int npre;
        bit sfd;
        bit bad;
        int len;
        int sfd_ts;
        int exp_beats;
        int exp_desc;
        int exp_len;
        bit exp_err;
        int dfrm;
        int derr;
    } vec_t;

    vec_t        tbl[12];
    logic [15:0] t_frm = 16'd0;
    logic [15:0] t_err = 16'd0;

    initial begin
        //          npre sfd bad len   ts    beats desc len  err dfrm derr
        tbl[0]  = '{7,   1,  0,  64,   1000, 64,   1,   64,   0,  1,  0};
        tbl[1]  = '{7,   1,  0,  20,   -1,   20,   1,   20,   1,  0,  1};
        tbl[2]  = '{2,   0,  1,  60,   -1,   0,    0,   0,    0,  0,  1};
        tbl[3]  = '{7,   1,  0,  64,   -1,   64,   1,   64,   0,  1,  0};
        tbl[4]  = '{3,   1,  0,  1,    -1,   1,    1,   1,    1,  0,  1};
        tbl[5]  = '{7,   1,  0,  0,    -1,   0,    1,   0,    1,  0,  1};
        tbl[6]  = '{4,   0,  0,  0,    -1,   0,    0,   0,    0,  0,  1};
        tbl[7]  = '{0,   0,  1,  10,   -1,   0,    0,   0,    0,  0,  1};
        tbl[8]  = '{7,   1,  0,  63,   -1,   63,   1,   63,   1,  0,  1};
        tbl[9]  = '{7,   1,  0,  65,   -1,   65,   1,   65,   0,  1,  0};
        tbl[10] = '{1,   1,  0,  1522, -1,   1522, 1,   1522, 0,  1,  0};
        tbl[11] = '{7,   1,  0,  1600, -1,   1522, 1,   1522, 1,  0,  1};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset rx_data", 64'(rx_data), 64'd0);
        chk("reset rx_valid", 64'(rx_valid), 64'd0);
        chk("reset rx_sop", 64'(rx_sop), 64'd0);
        chk("reset rx_eop", 64'(rx_eop), 64'd0);
        chk("reset rx_err", 64'(rx_err), 64'd0);
        chk("reset desc_valid", 64'(desc_valid), 64'd0);
        chk("reset desc_len", 64'(desc_len), 64'd0);
        chk("reset desc_ts", 64'(desc_ts), 64'd0);
        chk("reset desc_err", 64'(desc_err), 64'd0);
        chk("reset frame_cnt", 64'(frame_cnt), 64'd0);
        chk("reset err_cnt", 64'(err_cnt), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) tick(8'h00, 1'b0);

        // Table-driven frames.
        for (int r = 0; r < 12; r++) begin
            frm.delete();
            for (int i = 0; i < tbl[r].npre; i++) frm.push_back(8'h55);
            if (tbl[r].bad) frm.push_back(8'hAA);
            if (tbl[r].sfd) frm.push_back(8'hD5);
            for (int i = 0; i < tbl[r].len; i++) frm.push_back(8'(i + 37 * r));
            if (tbl[r].sfd_ts >= 0) local_clock = 32'(tbl[r].sfd_ts - tbl[r].npre);
            send(3);
            model();
            t_frm = t_frm + 16'(tbl[r].dfrm);
            t_err = t_err + 16'(tbl[r].derr);
            chk($sformatf("row%0d beats", r), 64'(got_b.size()), 64'(tbl[r].exp_beats));
            chk($sformatf("row%0d descs", r), 64'(got_d.size()), 64'(tbl[r].exp_desc));
            if (got_d.size() > 0) begin
                chk($sformatf("row%0d desc_len", r), 64'(got_d[0].len), 64'(tbl[r].exp_len));
                chk($sformatf("row%0d desc_err", r), 64'(got_d[0].err), 64'(tbl[r].exp_err));
                if (tbl[r].sfd_ts >= 0)
                    chk($sformatf("row%0d desc_ts", r), 64'(got_d[0].ts), 64'(tbl[r].sfd_ts));
            end
            chk($sformatf("row%0d frame_cnt", r), 64'(frame_cnt), 64'(t_frm));
            chk($sformatf("row%0d err_cnt", r), 64'(err_cnt), 64'(t_err));
            compare_all($sformatf("row%0d", r));
        end

        // Back-to-back frames with a single idle cycle between them.
        frm.delete();
        add_pre_sfd();
        for (int i = 0; i < 100; i++) frm.push_back(8'(255 - i));
        send(1);
        model();
        frm.delete();
        add_pre_sfd();
        for (int i = 0; i < 64; i++) frm.push_back(8'(3 * i));
        send(3);
        model();
        chk("b2b desc count", 64'(got_d.size()), 64'd2);
        if (got_d.size() >= 2) begin
            chk("b2b len0", 64'(got_d[0].len), 64'd100);
            chk("b2b len1", 64'(got_d[1].len), 64'd64);
            chk("b2b ts diff", 64'(got_d[1].ts - got_d[0].ts), 64'd109);
        end
        compare_all("b2b");

        // Random frames against the reference model.
        for (int k = 0; k < 40; k++) begin
            int          kind, npre, len;
            logic [7:0]  b;
            kind = int'($urandom_range(0, 9));
            npre = int'($urandom_range(1, 7));
            frm.delete();
            for (int i = 0; i < npre; i++) frm.push_back(8'h55);
            if (kind == 0) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'h55 || b == 8'hD5) b = 8'hAA;
                frm.push_back(b);
                len = int'($urandom_range(0, 30));
            end else if (kind == 1) begin
                len = 0;
            end else begin
                frm.push_back(8'hD5);
                if (kind == 2) len = int'($urandom_range(0, 2));
                else if (kind == 3) len = int'($urandom_range(MIN_LEN - 1, MIN_LEN + 1));
                else len = int'($urandom_range(1, 200));
                if (k == 20) len = MAX_LEN + 1;
            end
            for (int i = 0; i < len; i++) frm.push_back(8'($urandom_range(0, 255)));
            local_clock = $urandom();
            send(int'($urandom_range(1, 3)));
            model();
            if (k % 8 == 7) compare_all($sformatf("rand%0d", k));
        end
        compare_all("rand end");

        // Reset in the middle of a 200-byte frame, released while RXDV is high.
        frm.delete();
        add_pre_sfd();
        for (int i = 0; i < 200; i++) frm.push_back(8'(i));
        for (int i = 0; i < 108; i++) tick(frm[i], 1'b1);
        rst = 1'b1;
        #1;
        got_b.delete(); got_d.delete(); exp_b.delete(); exp_d.delete();
        m_frm = 16'd0;
        m_err = 16'd0;
        have_d = 1'b0;
        chk("midrst rx_valid", 64'(rx_valid), 64'd0);
        chk("midrst rx_data", 64'(rx_data), 64'd0);
        chk("midrst desc_len", 64'(desc_len), 64'd0);
        chk("midrst frame_cnt", 64'(frame_cnt), 64'd0);
        chk("midrst err_cnt", 64'(err_cnt), 64'd0);
        for (int i = 108; i < 111; i++) tick(frm[i], 1'b1);
        rst = 1'b0;
        for (int i = 111; i < 208; i++) tick(frm[i], 1'b1);
        for (int i = 0; i < 3; i++) tick(8'h00, 1'b0);
        chk("midrst no beats", 64'(got_b.size()), 64'd0);
        chk("midrst no desc", 64'(got_d.size()), 64'd0);
        chk("midrst err_cnt after", 64'(err_cnt), 64'd0);
        frm.delete();
        add_pre_sfd();
        for (int i = 0; i < 64; i++) frm.push_back(8'(i + 9));
        send(3);
        model();
        chk("postrst frame_cnt", 64'(frame_cnt), 64'd1);
        if (got_d.size() > 0) chk("postrst desc_len", 64'(got_d[0].len), 64'd64);
        compare_all("postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gmii_rx_ts.md
# gmii_rx_ts

Synthesizable byte-wide receive front end for a host port of the emulated TSN network. It consumes the RXD/RXDV byte stream that a host transmit model or a switch port drives, and strips preamble and SFD. It captures `local_clock` at the SFD byte and forwards frame bytes on a sop/eop stream, then emits one per-frame descriptor carrying length, receive timestamp and error flag.

## Interface
- `MAX_LEN`, 1522: largest accepted frame in bytes, FCS included; must be ≤ 2047.
- `MIN_LEN`, 64: smallest accepted frame in bytes, FCS included.
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `local_clock`  in  32: free-running network time.
- `RXD`  in  8: receive byte.
- `RXDV`  in  1: receive byte valid.
- `rx_data`  out  8: frame byte (preamble/SFD removed).
- `rx_valid`  out  1: `rx_data` valid.
- `rx_sop`  out  1: first byte of frame.
- `rx_eop`  out  1: last byte of frame.
- `rx_err`  out  1: with `rx_eop`; frame is runt or truncated.
- `desc_valid`  out  1: one-cycle descriptor pulse.
- `desc_len`  out  11: bytes forwarded for the frame.
- `desc_ts`  out  32: `local_clock` sampled at SFD.
- `desc_err`  out  1: same meaning as `rx_err`.
- `frame_cnt`  out  16: good frames received.
- `err_cnt`  out  16: preamble, runt and oversize errors.

## Operation
- States:
  - IDLE
  - PRE: preamble.
  - DATA
  - DROP: wait for RXDV low.
- `rxdv_d` is RXDV registered one cycle. Its reset value is 1, so a frame already in progress at reset release is ignored until RXDV goes low.
- IDLE:
  - Transition RXDV=1 with `rxdv_d`=0 and RXD=0x55 → PRE, with `pre_cnt`=1.
  - Transition RXDV=1 with `rxdv_d`=0 and any other RXD → DROP, with `err_cnt`+1.
- PRE, when RXDV=1:
  - RXD=0x55 → `pre_cnt`+1, saturating at 7.
  - RXD=0xD5 → DATA; `ts_reg` ← `local_clock` on the same edge; `len` ← 0.
  - Any other byte → DROP, `err_cnt`+1.
- PRE, when RXDV=0: → IDLE, `err_cnt`+1.
- One-byte hold register `hold`/`hold_full` is used so the last byte can be flagged eop.
- DATA, when RXDV=1 and `len` < MAX_LEN:
  - `hold` ← RXD, `len`+1.
  - If `hold_full` was set, the previous `hold` is presented on `rx_data` with `rx_valid`=1.
  - `rx_sop`=1 only for the first byte presented.
- DATA, when RXDV=0: present `hold` with `rx_eop`=1, then → IDLE.
  - `rx_err`/`desc_err` = (`len` < MIN_LEN).
  - Also drive `desc_valid`=1, `desc_len`=`len` and `desc_ts`=`ts_reg`.
  - `frame_cnt`+1 if there is no error; otherwise `err_cnt`+1.
- DATA, when RXDV=1 and `len`=MAX_LEN (oversize):
  - Present `hold` with `rx_eop`=1 and `rx_err`=1.
  - Descriptor with `desc_len`=MAX_LEN and `desc_err`=1.
  - `err_cnt`+1, then → DROP.
- Frame with zero data bytes (SFD then RXDV low): no stream output. Descriptor with `desc_len`=0, `desc_err`=1, `err_cnt`+1.
- A one-byte frame presents a single beat with `rx_sop`=`rx_eop`=1.
- DROP: RXDV=0 → IDLE; no output while in DROP.
- Counters are 16 bits and wrap modulo 2^16.
- `len` never exceeds MAX_LEN.

## Timing
- All outputs are registered.
- Reset values:
  - `rx_data`=0, `rx_valid`/`rx_sop`/`rx_eop`/`rx_err`=0.
  - `desc_valid`=0, `desc_len`=0, `desc_ts`=0, `desc_err`=0.
  - `frame_cnt`=0, `err_cnt`=0.
  - FSM in IDLE, `rxdv_d`=1, `hold_full`=0.
- Latency: a data byte sampled at edge t appears on `rx_data` in the cycle after edge t+1 (2 clocks).
  - The exception is the last byte, which appears in the cycle after the edge that samples RXDV=0.
- `desc_valid` pulses in the same cycle as `rx_eop`.
  - `desc_len`/`desc_ts`/`desc_err` hold their values until the next descriptor.
- `rx_valid`, `rx_sop`, `rx_eop`, `rx_err` and `desc_valid` are single-cycle per beat; there is no backpressure.
- Minimum inter-frame gap is 1 cycle of RXDV=0; the next preamble may start on the following cycle.
- `desc_ts` equals `local_clock` at the edge that samples the SFD.
- Reset asserted mid-frame: outputs clear immediately and no eop/descriptor is produced for that frame.

## Test plan
- 7×0x55, 0xD5, 64 bytes 0x00..0x3F; `local_clock`=1000 at the SFD edge → 64 beats 0x00..0x3F, sop on the first, eop on the last, `rx_err`=0, `desc_len`=64, `desc_ts`=1000, `frame_cnt`=1.
- Runt: 7×0x55, 0xD5, 20 bytes → 20 beats, eop with `rx_err`=1, `desc_len`=20, `desc_err`=1, `err_cnt`=1, `frame_cnt` unchanged.
- Oversize: 1600 bytes with MAX_LEN=1522 → exactly 1522 beats, the 1522nd with eop+err, `desc_len`=1522, no beats until RXDV low, `err_cnt`+1.
- Bad preamble: 0x55 0x55 0xAA then 60 bytes → zero `rx_valid`, no `desc_valid`, `err_cnt`+1; the next good frame is received normally.
- Back-to-back: 100-byte frame, 1 cycle RXDV=0, 64-byte frame; `local_clock` increments by 1 per cycle → two descriptors with `desc_len` 100 and 64, and a `desc_ts` difference of 109, `frame_cnt`=2.
- Reset for 3 cycles in the middle of a 200-byte frame, released with RXDV=1 → no output for the rest of that frame; the next 64-byte frame gives `desc_len`=64, `frame_cnt`=1.
